// File: rtl/ads_touch_scan.sv
// SPI master for the ADS7843 touch controller: runs an X+Y 12-bit conversion pair and
// exposes results, status and a scan counter on a small Avalon-MM register slave.
module ads_touch_scan #(
  parameter int unsigned CLK_DIV = 25
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        ads_cs_n,
  output logic        ads_dclk,
  output logic        ads_din,
  input  logic        ads_dout,
  input  logic        ads_penirq_n
);

  localparam int unsigned DivW = $clog2(CLK_DIV);

  typedef enum logic [2:0] {StIdle, StSetup, StConvX, StConvY, StHold} state_e;

  state_e          state_q, state_d;
  logic [DivW-1:0] div_q, div_d;
  logic [5:0]      half_q, half_d;
  logic [23:0]     shift_q, shift_d;
  logic [11:0]     x_tmp_q, x_q, y_q;
  logic [15:0]     count_q;
  logic            valid_q, overrun_q, auto_q;
  logic            dout_meta, dout_sync, pen_meta, pen_sync;
  logic            tick, sample, x_end, done, busy, pen_down;
  logic            start_req, wr0, rd0, rd1;
  logic            conv_d, cs_n_d, dclk_d, din_d;
  logic [7:0]      cmd_d;
  logic [2:0]      bit_idx;
  logic [31:0]     rdata_d;
  logic            unused_wdata;

  assign unused_wdata = ^writedata[31:2];

  assign pen_down  = ~pen_sync;
  assign busy      = (state_q != StIdle);
  assign tick      = (div_q == DivW'(CLK_DIV - 1));
  assign wr0       = write && (address == 2'd0);
  assign rd0       = read && (address == 2'd0);
  assign rd1       = read && (address == 2'd1);
  assign start_req = wr0 && writedata[0];
  // Sample on the last clk of each DCLK high phase (odd half-periods).
  assign sample    = ((state_q == StConvX) || (state_q == StConvY)) && half_q[0] && tick;
  assign shift_d   = sample ? {shift_q[22:0], dout_sync} : shift_q;

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    half_d  = half_q;
    x_end   = 1'b0;
    done    = 1'b0;
    if (state_q != StIdle) begin
      div_d = tick ? '0 : div_q + 1'b1;
    end
    unique case (state_q)
      StIdle: begin
        if (start_req || (auto_q && pen_down)) begin
          state_d = StSetup;
          div_d   = '0;
        end
      end
      StSetup: begin
        if (tick) begin
          state_d = StConvX;
          half_d  = '0;
        end
      end
      StConvX: begin
        if (tick) begin
          if (half_q == 6'd47) begin
            state_d = StConvY;
            half_d  = '0;
            x_end   = 1'b1;
          end else begin
            half_d = half_q + 6'd1;
          end
        end
      end
      StConvY: begin
        if (tick) begin
          if (half_q == 6'd47) begin
            state_d = StHold;
            half_d  = '0;
          end else begin
            half_d = half_q + 6'd1;
          end
        end
      end
      StHold: begin
        if (tick) begin
          state_d = StIdle;
          done    = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Pin outputs are registered from next-state so DCLK/DIN/CS never glitch.
  always_comb begin
    conv_d  = (state_d == StConvX) || (state_d == StConvY);
    cmd_d   = (state_d == StConvX) ? 8'hD0 : 8'h90;
    bit_idx = ~half_d[3:1];
    cs_n_d  = (state_d == StIdle);
    dclk_d  = conv_d && half_d[0];
    din_d   = conv_d && (half_d[5:4] == 2'b00) && cmd_d[bit_idx];
  end

  always_comb begin
    rdata_d = '0;
    unique case (address)
      2'd0:    rdata_d = {27'b0, auto_q, overrun_q, pen_down, valid_q, busy};
      2'd1:    rdata_d = {valid_q, 3'b0, y_q, 4'b0, x_q};
      2'd2:    rdata_d = {16'b0, count_q};
      default: rdata_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dout_meta <= 1'b0;
      dout_sync <= 1'b0;
      pen_meta  <= 1'b1;
      pen_sync  <= 1'b1;
    end else begin
      dout_meta <= ads_dout;
      dout_sync <= dout_meta;
      pen_meta  <= ads_penirq_n;
      pen_sync  <= pen_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      div_q     <= '0;
      half_q    <= '0;
      shift_q   <= '0;
      x_tmp_q   <= '0;
      x_q       <= '0;
      y_q       <= '0;
      count_q   <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      auto_q    <= 1'b0;
      ads_cs_n  <= 1'b1;
      ads_dclk  <= 1'b0;
      ads_din   <= 1'b0;
      readdata  <= '0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      half_q   <= half_d;
      shift_q  <= shift_d;
      ads_cs_n <= cs_n_d;
      ads_dclk <= dclk_d;
      ads_din  <= din_d;
      readdata <= rdata_d;
      if (x_end) begin
        x_tmp_q <= shift_d[14:3];
      end
      if (wr0) begin
        auto_q <= writedata[1];
      end
      // Completion takes priority over clear-on-read.
      if (done) begin
        x_q       <= x_tmp_q;
        y_q       <= shift_q[14:3];
        valid_q   <= 1'b1;
        overrun_q <= overrun_q | valid_q;
        count_q   <= count_q + 16'd1;
      end else if (rd1) begin
        valid_q   <= 1'b0;
        overrun_q <= 1'b0;
      end else if (rd0) begin
        overrun_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ads_touch_scan.sv
// Directed bench for ads_touch_scan with a behavioural ADS7843 model on the SPI pins.
module tb_ads_touch_scan;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  address = 2'd0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        ads_cs_n, ads_dclk, ads_din;
  logic        ads_dout = 1'b0;
  logic        ads_penirq_n = 1'b1;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int t0 = 0;

  ads_touch_scan #(.CLK_DIV(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .address      (address),
    .read         (read),
    .write        (write),
    .writedata    (writedata),
    .readdata     (readdata),
    .ads_cs_n     (ads_cs_n),
    .ads_dclk     (ads_dclk),
    .ads_din      (ads_din),
    .ads_dout     (ads_dout),
    .ads_penirq_n (ads_penirq_n)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ADS7843 model: latches 8 command bits on rising edges 1..8, then presents
  // D11..D0 so that D11 is valid at rising edge 10 and D0 at rising edge 21.
  logic [11:0] x_val = 12'hA5C;
  logic [11:0] y_val = 12'h3F1;
  logic [11:0] cur_val;
  logic [7:0]  cmd_sh = '0;
  logic [7:0]  cmd_log [64];
  int          cmd_n = 0;
  int          ec = 0;
  int          next_ec;
  int          dclk_edges = 0;

  assign next_ec = (ec >= 24) ? 1 : ec + 1;
  assign cur_val = (cmd_sh[7:4] == 4'hD) ? x_val : y_val;

  always @(posedge ads_dclk) begin
    dclk_edges <= dclk_edges + 1;
    ec <= next_ec;
    if (next_ec <= 8) cmd_sh <= {cmd_sh[6:0], ads_din};
    if (next_ec == 8) begin
      cmd_log[cmd_n % 64] <= {cmd_sh[6:0], ads_din};
      cmd_n <= cmd_n + 1;
    end
  end

  always @(negedge ads_dclk) begin
    if (ec >= 9 && ec <= 20) ads_dout <= cur_val[20 - ec];
    else ads_dout <= 1'b0;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; write = 1'b1;
    @(negedge clk);
    write = 1'b0; address = 2'd0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a; read = 1'b1;
    @(negedge clk);
    read = 1'b0; d = readdata; address = 2'd0;
  endtask

  task automatic start_scan();
    wr(2'd0, 32'h1);
    t0 = cyc;
  endtask

  // Length in clk cycles from the accepting edge to the edge that raises CS; -1 on timeout.
  task automatic wait_done(output int len);
    len = -1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (ads_cs_n) begin
        len = cyc - t0;
        break;
      end
    end
  endtask

  logic [31:0] d;
  int          len, e0;

  initial begin
    // Reset
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_cs_n", 32'(ads_cs_n), 32'd1);
    check("rst_dclk", 32'(ads_dclk), 32'd0);
    check("rst_din", 32'(ads_din), 32'd0);
    check("rst_readdata", readdata, 32'd0);
    rd(2'd0, d); check("rst_status", d, 32'd0);
    rd(2'd1, d); check("rst_data", d, 32'd0);
    rd(2'd2, d); check("rst_count", d, 32'd0);

    // Single scan
    e0 = dclk_edges;
    start_scan();
    wait_done(len);
    check("scan_len", 32'(len), 32'd392);
    // address 0 is held: readdata still shows pre-completion status, valid appears next cycle
    check("status_busy_end", readdata, 32'h01);
    @(negedge clk);
    check("status_valid", readdata, 32'h02);
    check("dclk_edges", 32'(dclk_edges - e0), 32'd48);
    check("cmd_x", 32'(cmd_log[(cmd_n - 2) % 64]), 32'hD0);
    check("cmd_y", 32'(cmd_log[(cmd_n - 1) % 64]), 32'h90);
    rd(2'd1, d); check("data_first", d, 32'h83F10A5C);
    rd(2'd1, d); check("data_cleared", d, 32'h03F10A5C);
    rd(2'd2, d); check("count_1", d, 32'd1);
    rd(2'd3, d); check("addr3", d, 32'd0);

    // Overrun
    start_scan(); wait_done(len); check("ovr_len1", 32'(len), 32'd392);
    start_scan(); wait_done(len); check("ovr_len2", 32'(len), 32'd392);
    @(negedge clk);
    rd(2'd0, d); check("ovr_status", d, 32'h0A);
    rd(2'd0, d); check("ovr_cleared", d, 32'h02);
    rd(2'd1, d); check("ovr_data", d, 32'h83F10A5C);
    rd(2'd2, d); check("count_3", d, 32'd3);

    // Start write during a running scan is ignored
    start_scan();
    repeat (98) @(negedge clk);
    wr(2'd0, 32'h1);
    wait_done(len);
    check("ign_len", 32'(len), 32'd392);
    repeat (20) @(negedge clk);
    check("ign_idle", 32'(ads_cs_n), 32'd1);
    rd(2'd2, d); check("count_4", d, 32'd4);
    rd(2'd1, d);

    // Auto mode: three back-to-back pairs while the pen stays down
    ads_penirq_n = 1'b0;
    repeat (4) @(negedge clk);
    wr(2'd0, 32'h2);
    repeat (2 * 393 + 200) @(negedge clk);
    ads_penirq_n = 1'b1;
    wait_done(len);
    check("auto_done", 32'(len >= 0), 32'd1);
    e0 = dclk_edges;
    repeat (800) @(negedge clk);
    check("auto_no_edges", 32'(dclk_edges - e0), 32'd0);
    check("auto_cs_idle", 32'(ads_cs_n), 32'd1);
    rd(2'd2, d); check("count_7", d, 32'd7);
    rd(2'd0, d); check("auto_status", d, 32'h1A);
    rd(2'd0, d); check("auto_status_clr", d, 32'h12);
    wr(2'd0, 32'h0);

    // Reset mid-scan
    start_scan();
    repeat (150) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_cs_n", 32'(ads_cs_n), 32'd1);
    check("midrst_dclk", 32'(ads_dclk), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    e0 = dclk_edges;
    rd(2'd0, d); check("midrst_status", d, 32'd0);
    rd(2'd1, d); check("midrst_data", d, 32'd0);
    rd(2'd2, d); check("midrst_count", d, 32'd0);
    repeat (500) @(negedge clk);
    check("midrst_no_edges", 32'(dclk_edges - e0), 32'd0);
    check("midrst_cs_idle", 32'(ads_cs_n), 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
